hazard_stall_ctrl: RTL

- Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve.
- Load-use hazards: holds PC and IF/ID for one cycle and inserts a bubble into ID/EX.
- Taken branches: flushes IF/ID.
- Multi-cycle data-memory access: freezes the whole pipeline until memory acknowledges, with a watchdog timeout and sticky error.
- Counts stall cycles for performance monitoring.

---
 rtl/hazard_stall_ctrl_pkg.sv | 6 +
 rtl/hazard_stall_ctrl_sat_counter.sv | 15 +
 rtl/hazard_stall_ctrl.sv | 59 +++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_pkg: shared state encoding and constants for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_ERR} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MEM_TIMEOUT_DEF = 255;
endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with sync clear and async active-low reset
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall, branch flush and data-memory freeze sequencing for the 5-stage core
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IDEX_mem_read,
  input  logic [4:0]       IDEX_Rt,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_uses_rt,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             PC_we,
  output logic             IFID_we,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);
  state_t state, state_nxt;
  logic [TO_W-1:0] wait_cnt;
  logic mem_busy, load_use, freeze, advance;
  assign mem_busy = dmem_req & ~dmem_ack;
  assign load_use = IDEX_mem_read & (IDEX_Rt != REG_ZERO) &
                    ((IDEX_Rt == IFID_Rs) | (IFID_uses_rt & (IDEX_Rt == IFID_Rt)));
  assign freeze   = (state == ST_ERR) | mem_busy;
  assign advance  = rst_n & ~freeze & ~load_use;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_RUN;
    else state <= state_nxt;
  // wait_cnt counts consecutive busy cycles, so it reads 1 on the first MEM_WAIT cycle
  always_comb begin
    state_nxt = (state == ST_ERR) ? ST_ERR :
                !mem_busy ? ST_RUN :
                (state == ST_MEM_WAIT && wait_cnt == TO_W'(MEM_TIMEOUT)) ? ST_ERR : ST_MEM_WAIT;
  end
  // reset forces a flushing, non-advancing pipeline
  always_comb begin
    PC_we       = advance;
    IFID_we     = advance;
    IFID_flush  = ~rst_n | (advance & branch_taken);
    IDEX_bubble = ~rst_n | (rst_n & ~freeze & load_use);
    pipe_freeze = rst_n & freeze;
  end
  assign mem_err = (state == ST_ERR);
  sat_counter #(.W(TO_W)) u_wait (
    .clk(clk), .rst_n(rst_n), .clr(~mem_busy | (state == ST_ERR)), .inc(1'b1), .cnt(wait_cnt)
  );
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .inc(~PC_we), .cnt(stall_cycles)
  );
endmodule
